// File: rtl/dvs_event_fifo.sv
// Event FIFO behind the AER front end: grants one event per request pulse,
// buffers it and serves the head on a valid/ready port.
module dvs_event_fifo #(
  parameter int DEPTH          = 16,
  parameter int EVENT_W        = 12,
  parameter bit DROP_WHEN_FULL = 1'b0,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_req,
  input  logic [EVENT_W-1:0]       fifo_bus_event,
  output logic                     fifo_grant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EVENT_W-1:0]       out_event,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [EVENT_W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [0:0]            r_state;
  logic                  r_grant;
  logic [DROP_CNT_W-1:0] r_drop;

  logic w_full;
  logic w_idle_req;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // Full is judged on the pre-edge level, so a same-edge pop cannot admit a write.
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_idle_req = (r_state == S_IDLE) && fifo_req;
  assign w_push     = w_idle_req && !w_full;
  assign w_drop     = w_idle_req && w_full && DROP_WHEN_FULL;
  assign w_pop      = (r_level != '0) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_push || w_drop) begin
          r_state <= S_HOLD;
          r_grant <= 1'b1;
        end
      end else if (!fifo_req) begin
        r_state <= S_IDLE;
        r_grant <= 1'b0;
      end

      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);

      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LW'(1);

      if (w_drop && (r_drop != '1))
        r_drop <= r_drop + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= fifo_bus_event;
  end

  assign fifo_grant = r_grant;
  assign out_valid  = (r_level != '0);
  assign out_event  = r_mem[r_rd_ptr];
  assign level      = r_level;
  assign full       = w_full;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_dvs_event_fifo.sv
// Bench for dvs_event_fifo: stall-mode and drop-mode instances checked
// every cycle against a queue model, plus directed literal checks.
module tb_dvs_event_fifo;

  localparam int DEPTH = 16;
  localparam int EW    = 12;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req   [2];
  logic [EW-1:0] ev    [2];
  logic          rdy   [2];
  logic          grant [2];
  logic          valid [2];
  logic [EW-1:0] oev   [2];
  logic [LW-1:0] lvl   [2];
  logic          full  [2];
  logic [15:0]   dc    [2];

  int vectors = 0;
  int errors  = 0;
  bit armed   = 1'b0;

  logic [EW-1:0] mq [2][$];
  bit            mg [2];
  int            mdc[2];

  always #5 clk = ~clk;

  dvs_event_fifo #(
    .DEPTH(DEPTH), .EVENT_W(EW), .DROP_WHEN_FULL(1'b0), .DROP_CNT_W(16)
  ) u_stall (
    .clk(clk), .rst_n(rst_n),
    .fifo_req(req[0]), .fifo_bus_event(ev[0]), .fifo_grant(grant[0]),
    .out_valid(valid[0]), .out_ready(rdy[0]), .out_event(oev[0]),
    .level(lvl[0]), .full(full[0]), .drop_count(dc[0])
  );

  dvs_event_fifo #(
    .DEPTH(DEPTH), .EVENT_W(EW), .DROP_WHEN_FULL(1'b1), .DROP_CNT_W(16)
  ) u_drop (
    .clk(clk), .rst_n(rst_n),
    .fifo_req(req[1]), .fifo_bus_event(ev[1]), .fifo_grant(grant[1]),
    .out_valid(valid[1]), .out_ready(rdy[1]), .out_event(oev[1]),
    .level(lvl[1]), .full(full[1]), .drop_count(dc[1])
  );

  task automatic cmp(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %0h want %0h", name, k, $time, act, exp);
    end
  endtask

  // Queue model: one event per request pulse, full judged before the pop.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          mq[k].delete();
          mg[k]  = 1'b0;
          mdc[k] = 0;
        end else begin
          int sz;
          bit pop;
          sz  = mq[k].size();
          pop = (sz != 0) && rdy[k];
          if (!mg[k]) begin
            if (req[k]) begin
              if (sz < DEPTH) begin
                mq[k].push_back(ev[k]);
                mg[k] = 1'b1;
              end else if (k == 1) begin
                mg[k] = 1'b1;
                if (mdc[k] < 65535) mdc[k]++;
              end
            end
          end else if (!req[k]) begin
            mg[k] = 1'b0;
          end
          if (pop) void'(mq[k].pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          int sz;
          sz = mq[k].size();
          cmp("grant", k, 32'(grant[k]), 32'(mg[k]));
          cmp("valid", k, 32'(valid[k]), 32'(sz != 0));
          cmp("level", k, 32'(lvl[k]), 32'(sz));
          cmp("full", k, 32'(full[k]), 32'(sz == DEPTH));
          cmp("drop_count", k, 32'(dc[k]), 32'(mdc[k]));
          if (sz != 0) cmp("event", k, 32'(oev[k]), 32'(mq[k][0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k, input logic [EW-1:0] e);
    req[k] = 1'b1;
    ev[k]  = e;
    step();
    req[k] = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0;
      ev[k]  = '0;
      rdy[k] = 1'b0;
    end
    step();
    step();
    armed = 1'b1;
    cmp("rst_grant", 0, 32'(grant[0]), 32'd0);
    cmp("rst_valid", 0, 32'(valid[0]), 32'd0);
    cmp("rst_level", 0, 32'(lvl[0]), 32'd0);
    cmp("rst_drop", 1, 32'(dc[1]), 32'd0);
    rst_n = 1'b1;

    // Single event through with the consumer ready.
    req[0] = 1'b1; ev[0] = 12'h1A5; rdy[0] = 1'b1;
    step();
    cmp("t1_grant", 0, 32'(grant[0]), 32'd1);
    cmp("t1_valid", 0, 32'(valid[0]), 32'd1);
    cmp("t1_event", 0, 32'(oev[0]), 32'h1A5);
    cmp("t1_level", 0, 32'(lvl[0]), 32'd1);
    req[0] = 1'b0;
    step();
    cmp("t1_drain", 0, 32'(lvl[0]), 32'd0);
    cmp("t1_grant_off", 0, 32'(grant[0]), 32'd0);
    rdy[0] = 1'b0;

    // Long request: a single write, grant held until req falls.
    req[0] = 1'b1; ev[0] = 12'h055;
    step();
    repeat (9) step();
    cmp("t5_grant_held", 0, 32'(grant[0]), 32'd1);
    cmp("t5_one_write", 0, 32'(lvl[0]), 32'd1);
    req[0] = 1'b0;
    step();
    cmp("t5_grant_fall", 0, 32'(grant[0]), 32'd0);
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;

    // Fill to full, stall the 17th, then same-cycle pop refuses the write.
    for (int i = 0; i < 16; i++) pulse(0, EW'(12'h100 + i));
    cmp("t2_full", 0, 32'(full[0]), 32'd1);
    cmp("t2_level", 0, 32'(lvl[0]), 32'd16);
    req[0] = 1'b1; ev[0] = 12'h2AA;
    repeat (3) step();
    cmp("t2_stalled", 0, 32'(grant[0]), 32'd0);
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;
    cmp("t4_refused", 0, 32'(grant[0]), 32'd0);
    cmp("t4_level15", 0, 32'(lvl[0]), 32'd15);
    step();
    cmp("t4_granted", 0, 32'(grant[0]), 32'd1);
    cmp("t4_level16", 0, 32'(lvl[0]), 32'd16);
    req[0] = 1'b0;
    step();
    rdy[0] = 1'b1;
    for (int i = 1; i < 16; i++) begin
      cmp("t2_order", 0, 32'(oev[0]), 32'h100 + 32'(i));
      step();
    end
    cmp("t2_tail", 0, 32'(oev[0]), 32'h2AA);
    step();
    rdy[0] = 1'b0;
    cmp("t2_empty", 0, 32'(valid[0]), 32'd0);

    // Drop mode: full FIFO grants and discards three more events.
    for (int i = 0; i < 16; i++) pulse(1, EW'(12'h100 + i));
    for (int i = 0; i < 3; i++) begin
      req[1] = 1'b1; ev[1] = 12'h3FF;
      step();
      cmp("t3_grant", 1, 32'(grant[1]), 32'd1);
      req[1] = 1'b0;
      step();
    end
    cmp("t3_drops", 1, 32'(dc[1]), 32'd3);
    cmp("t3_level", 1, 32'(lvl[1]), 32'd16);
    cmp("t3_head", 1, 32'(oev[1]), 32'h100);
    rdy[1] = 1'b1;
    repeat (16) step();
    rdy[1] = 1'b0;
    cmp("t3_drained", 1, 32'(lvl[1]), 32'd0);

    // Reset while holding the grant with five entries buffered.
    for (int i = 0; i < 4; i++) pulse(0, EW'(12'h0C0 + i));
    req[0] = 1'b1; ev[0] = 12'h0C4;
    step();
    cmp("t6_pre_grant", 0, 32'(grant[0]), 32'd1);
    cmp("t6_pre_level", 0, 32'(lvl[0]), 32'd5);
    rst_n = 1'b0;
    step();
    cmp("t6_grant", 0, 32'(grant[0]), 32'd0);
    cmp("t6_level", 0, 32'(lvl[0]), 32'd0);
    cmp("t6_valid", 0, 32'(valid[0]), 32'd0);
    rst_n  = 1'b1;
    req[0] = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
